// File: rtl/sccb_pkg.sv
// Shared SCCB responder definitions: FSM state encoding and the default write ID.
`timescale 1ns/1ps
package sccb_pkg;

  localparam logic [7:0] SCCB_WRITE_ID = 8'h42;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ID,
    ST_ID_ACK,
    ST_SUB,
    ST_SUB_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RD_NACK,
    ST_IGNORE
  } sccb_state_e;

endpackage

// File: rtl/sccb_line_sync.sv
// Two-flop synchronizer for one SCCB line plus rise/fall detection on the synchronized level.
`timescale 1ns/1ps
module sccb_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [1:0] sync_q;
  logic       prev_q;

  // NOTE: flops use non-blocking assignments so every stage samples the pre-edge value of the stage before it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], line_i};
      prev_q <= sync_q[1];
    end
  end

  assign level_o = sync_q[1];
  assign rise_o  = sync_q[1] & ~prev_q;
  assign fall_o  = ~sync_q[1] & prev_q;

endmodule

// File: rtl/sccb_responder.sv
// SCCB (3-wire I2C-like) register-bus responder: one-byte writes and one-byte reads from the last sub-address.
`timescale 1ns/1ps
module sccb_responder
  import sccb_pkg::*;
#(
  parameter logic [7:0] DEVICE_ID = SCCB_WRITE_ID,
  parameter int         REG_AW    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sioc,
  inout  wire               siod,
  output logic              wr_en,
  output logic [REG_AW-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [REG_AW-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              busy
);

  localparam logic [7:0] READ_ID = DEVICE_ID | 8'h01;

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  sccb_line_sync u_scl_sync (
    .clk(clk), .rst(rst), .line_i(sioc),
    .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
  );

  sccb_line_sync u_sda_sync (
    .clk(clk), .rst(rst), .line_i(siod),
    .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
  );

  sccb_state_e       state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              rw_q, rw_d;
  logic              sda_low_q, sda_low_d;
  logic              busy_q, busy_d;
  logic [REG_AW-1:0] rd_addr_q, rd_addr_d;
  logic              wr_en_q, wr_en_d;
  logic [REG_AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;

  logic       start_det, stop_det, last_bit, ack_start, ack_done;
  logic [7:0] byte_in;

  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;
  assign byte_in   = {shift_q[6:0], sda_lvl};
  assign last_bit  = (cnt_q == 3'd7);
  // An ack slot spans two sioc falls: the first starts pulling low, the second ends the slot.
  assign ack_start = scl_fall & ~sda_low_q;
  assign ack_done  = scl_fall & sda_low_q;

  always_comb begin
    // NOTE: every _d takes its hold value first, so no branch below can leave a latch behind.
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    rw_d      = rw_q;
    sda_low_d = sda_low_q;
    busy_d    = busy_q;
    rd_addr_d = rd_addr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if (stop_det) begin
      state_d   = ST_IDLE;
      sda_low_d = 1'b0;
      busy_d    = 1'b0;
    end else if (start_det) begin
      state_d   = ST_ID;
      cnt_d     = 3'd0;
      sda_low_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_ID: begin
          if (scl_rise) begin
            shift_d = byte_in;
            cnt_d   = cnt_q + 3'd1;
            if (last_bit) begin
              if (byte_in == DEVICE_ID) begin
                state_d = ST_ID_ACK;
                rw_d    = 1'b0;
                busy_d  = 1'b1;
              end else if (byte_in == READ_ID) begin
                state_d = ST_ID_ACK;
                rw_d    = 1'b1;
                busy_d  = 1'b1;
              end else begin
                state_d = ST_IGNORE;
                busy_d  = 1'b0;
              end
            end
          end
        end
        ST_ID_ACK: begin
          if (ack_start) begin
            sda_low_d = 1'b1;
          end else if (ack_done) begin
            cnt_d = 3'd0;
            if (rw_q) begin
              // The ack-release fall is also the fall that presents the first read bit.
              state_d   = ST_RDATA;
              shift_d   = {rd_data[6:0], 1'b0};
              sda_low_d = ~rd_data[7];
            end else begin
              state_d   = ST_SUB;
              sda_low_d = 1'b0;
            end
          end
        end
        ST_SUB: begin
          if (scl_rise) begin
            shift_d = byte_in;
            cnt_d   = cnt_q + 3'd1;
            if (last_bit) begin
              rd_addr_d = byte_in;
              state_d   = ST_SUB_ACK;
            end
          end
        end
        ST_SUB_ACK: begin
          if (ack_start) begin
            sda_low_d = 1'b1;
          end else if (ack_done) begin
            sda_low_d = 1'b0;
            cnt_d     = 3'd0;
            state_d   = ST_WDATA;
          end
        end
        ST_WDATA: begin
          if (scl_rise) begin
            shift_d = byte_in;
            cnt_d   = cnt_q + 3'd1;
            if (last_bit) begin
              wr_en_d   = 1'b1;
              wr_addr_d = rd_addr_q;
              wr_data_d = byte_in;
              state_d   = ST_WDATA_ACK;
            end
          end
        end
        ST_WDATA_ACK: begin
          if (ack_start) begin
            sda_low_d = 1'b1;
          end else if (ack_done) begin
            sda_low_d = 1'b0;
            state_d   = ST_IGNORE;
          end
        end
        ST_RDATA: begin
          if (scl_fall) begin
            sda_low_d = ~shift_q[7];
            shift_d   = {shift_q[6:0], 1'b0};
          end else if (scl_rise) begin
            cnt_d = cnt_q + 3'd1;
            if (last_bit) state_d = ST_RD_NACK;
          end
        end
        ST_RD_NACK: begin
          if (scl_fall)      sda_low_d = 1'b0;
          else if (scl_rise) state_d   = ST_IGNORE;
        end
        default: begin
          sda_low_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 3'd0;
      shift_q   <= 8'h00;
      rw_q      <= 1'b0;
      sda_low_q <= 1'b0;
      busy_q    <= 1'b0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      rw_q      <= rw_d;
      sda_low_q <= sda_low_d;
      busy_q    <= busy_d;
      rd_addr_q <= rd_addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign siod    = sda_low_q ? 1'b0 : 1'bz;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign rd_addr = rd_addr_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_sccb_responder.sv
// Self-checking bench for sccb_responder: directed vector table, corner sequences and a randomized transaction model.
`timescale 1ns/1ps
module tb_sccb_responder;

  localparam logic [7:0] WR_ID = sccb_pkg::SCCB_WRITE_ID;
  localparam logic [7:0] RD_ID = WR_ID | 8'h01;
  localparam int         Q     = 5;

  typedef struct {
    logic [7:0] id;
    logic [7:0] sub;
    logic [7:0] data;
    int         nb;
    logic [2:0] exp_ack;
    bit         exp_wr;
    logic [7:0] exp_rd_addr;
    bit         exp_busy;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, sioc, m_low;
  wire        siod;
  logic       wr_en, busy;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] wr_log[$];
  logic [7:0]  mem[256];
  logic [7:0]  m_addr;
  vec_t        vecs[7];
  logic [7:0]  echo, rbyte;
  logic        ack_bit, seen;
  logic [2:0]  acks;

  always #5 clk = ~clk;

  // Open-drain bus: master and responder can only pull low.
  assign siod    = m_low ? 1'b0 : 1'bz;
  pullup (siod);
  assign rd_data = mem[rd_addr];

  sccb_responder #(.DEVICE_ID(WR_ID), .REG_AW(8)) dut (
    .clk(clk), .rst(rst), .sioc(sioc), .siod(siod),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
  );

  always @(negedge clk) if (wr_en === 1'b1) wr_log.push_back({wr_addr, wr_data});

  initial begin
    #800000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    if (sioc == 1'b0) begin
      m_low = 1'b0; wait_clk(Q);
      sioc  = 1'b1; wait_clk(Q);
    end
    m_low = 1'b1; wait_clk(Q);
    sioc  = 1'b0; wait_clk(Q);
  endtask

  task automatic bus_stop();
    m_low = 1'b1; wait_clk(Q);
    sioc  = 1'b1; wait_clk(Q);
    m_low = 1'b0; wait_clk(Q);
  endtask

  task automatic bit_cycle(input logic b, output logic s);
    m_low = ~b;   wait_clk(Q);
    sioc  = 1'b1; wait_clk(Q);
    s     = siod; wait_clk(Q);
    sioc  = 1'b0; wait_clk(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic [7:0] e, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(b[i], s);
      e[i] = s;
    end
    bit_cycle(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic m_ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, s);
      d[i] = s;
    end
    bit_cycle(~m_ack, s);
  endtask

  task automatic write3(input logic [7:0] id, input logic [7:0] sub, input logic [7:0] dat,
                        output logic [2:0] a);
    logic [7:0] e;
    logic       k;
    bus_start();
    send_byte(id, e, k);  a[0] = k;
    send_byte(sub, e, k); a[1] = k;
    send_byte(dat, e, k); a[2] = k;
    bus_stop();
  endtask

  // Byte-level reference: a write ID acks ID, sub-address and one data byte; a read ID returns
  // mem[last sub-address] for the first byte and an idle bus afterwards; other IDs are invisible.
  task automatic run_random(input int n);
    logic [7:0]  id, b, got, exp_b;
    logic [3:0]  got_acks, exp_acks;
    logic [15:0] exp_wr[$];
    logic        a;
    bit          is_w, is_r;
    int          r, nb;
    for (int t = 0; t < n; t++) begin
      wr_log.delete();
      exp_wr.delete();
      r  = $urandom_range(0, 9);
      id = (r < 4) ? WR_ID : (r < 7) ? RD_ID : 8'($urandom_range(0, 255));
      is_w = (id == WR_ID);
      is_r = (id == RD_ID);
      got_acks = 4'b0;
      exp_acks = {3'b000, is_w | is_r};
      bus_start();
      send_byte(id, got, a);
      got_acks[0] = a;
      check("rnd id echo", got, id);
      if (id[0] == 1'b0) begin
        nb = $urandom_range(0, 3);
        for (int k = 0; k < nb; k++) begin
          b = 8'($urandom_range(0, 255));
          send_byte(b, got, a);
          got_acks[k+1] = a;
          check("rnd wbyte echo", got, b);
          if (is_w && k < 2) exp_acks[k+1] = 1'b1;
          if (is_w && k == 0) m_addr = b;
          if (is_w && k == 1) begin
            exp_wr.push_back({m_addr, b});
            mem[m_addr] = b;
          end
        end
      end else begin
        nb = $urandom_range(1, 2);
        for (int k = 0; k < nb; k++) begin
          exp_b = (is_r && k == 0) ? mem[m_addr] : 8'hFF;
          read_byte(1'($urandom_range(0, 1)), got);
          check("rnd read data", got, exp_b);
        end
      end
      bus_stop();
      check("rnd acks", got_acks, exp_acks);
      check("rnd write count", wr_log.size(), exp_wr.size());
      for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++)
        check("rnd write addr/data", wr_log[i], exp_wr[i]);
      check("rnd rd_addr", rd_addr, m_addr);
      check("rnd busy idle", busy, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; sioc = 1'b1; m_low = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);

    vecs[0] = '{8'h42, 8'h12, 8'h80, 2, 3'b111, 1'b1, 8'h12, 1'b1};
    vecs[1] = '{8'h40, 8'h12, 8'h80, 2, 3'b000, 1'b0, 8'h12, 1'b0};
    vecs[2] = '{8'h42, 8'h0A, 8'h00, 1, 3'b011, 1'b0, 8'h0A, 1'b1};
    vecs[3] = '{8'h42, 8'hFF, 8'h00, 2, 3'b111, 1'b1, 8'hFF, 1'b1};
    vecs[4] = '{8'hC2, 8'h33, 8'h44, 2, 3'b000, 1'b0, 8'hFF, 1'b0};
    vecs[5] = '{8'h52, 8'h33, 8'h44, 2, 3'b000, 1'b0, 8'hFF, 1'b0};
    vecs[6] = '{8'h42, 8'h00, 8'hFF, 2, 3'b111, 1'b1, 8'h00, 1'b1};

    wait_clk(4);
    check("reset wr_en", wr_en, 1'b0);
    check("reset wr_addr", wr_addr, 8'h00);
    check("reset wr_data", wr_data, 8'h00);
    check("reset rd_addr", rd_addr, 8'h00);
    check("reset busy", busy, 1'b0);
    check("reset siod released", siod, 1'b1);
    rst = 1'b0;
    wait_clk(4);

    for (int i = 0; i < 7; i++) begin
      wr_log.delete();
      acks = 3'b000;
      bus_start();
      send_byte(vecs[i].id, echo, ack_bit);
      acks[0] = ack_bit;
      check("vec id echo", echo, vecs[i].id);
      check("vec busy in txn", busy, vecs[i].exp_busy);
      if (vecs[i].nb >= 1) begin
        send_byte(vecs[i].sub, echo, ack_bit);
        acks[1] = ack_bit;
        check("vec sub echo", echo, vecs[i].sub);
      end
      if (vecs[i].nb >= 2) begin
        send_byte(vecs[i].data, echo, ack_bit);
        acks[2] = ack_bit;
        check("vec data echo", echo, vecs[i].data);
      end
      bus_stop();
      check("vec acks", acks, vecs[i].exp_ack);
      check("vec write count", wr_log.size(), vecs[i].exp_wr ? 1 : 0);
      if (vecs[i].exp_wr && wr_log.size() > 0) begin
        check("vec write addr/data", wr_log[0], {vecs[i].sub, vecs[i].data});
        mem[vecs[i].sub] = vecs[i].data;
      end
      check("vec rd_addr", rd_addr, vecs[i].exp_rd_addr);
      check("vec busy after stop", busy, 1'b0);
    end

    // Two-phase read: set sub-address, STOP, then read it back through a fresh START.
    wr_log.delete();
    mem[8'h0A] = 8'h76;
    bus_start();
    send_byte(WR_ID, echo, ack_bit);
    send_byte(8'h0A, echo, ack_bit);
    bus_stop();
    bus_start();
    send_byte(RD_ID, echo, ack_bit);
    check("read id ack", ack_bit, 1'b1);
    read_byte(1'b0, rbyte);
    bus_stop();
    check("read pattern 0x76", rbyte, 8'h76);
    check("read rd_addr", rd_addr, 8'h0A);
    check("read no write", wr_log.size(), 0);

    // STOP after four sub-address bits: nothing is written and rd_addr keeps its old value.
    wr_log.delete();
    bus_start();
    send_byte(WR_ID, echo, ack_bit);
    bit_cycle(1'b1, seen); bit_cycle(1'b0, seen);
    bit_cycle(1'b1, seen); bit_cycle(1'b0, seen);
    bus_stop();
    check("short sub no write", wr_log.size(), 0);
    check("short sub rd_addr", rd_addr, 8'h0A);
    check("short sub busy", busy, 1'b0);
    check("short sub siod", siod, 1'b1);

    // Reset while the responder is pulling the ID ack low.
    bus_start();
    for (int i = 7; i >= 0; i--) bit_cycle(WR_ID[i], seen);
    m_low = 1'b0; wait_clk(Q);
    sioc  = 1'b1; wait_clk(Q);
    check("ack low before reset", siod, 1'b0);
    rst = 1'b1;
    wait_clk(1);
    check("siod released on reset", siod, 1'b0 ^ 1'b1);
    wait_clk(3);
    rst = 1'b0;
    wait_clk(Q);
    check("rd_addr cleared by reset", rd_addr, 8'h00);

    // Reset at the 5th WDATA bit, then a clean write must still go through.
    wr_log.delete();
    bus_start();
    send_byte(WR_ID, echo, ack_bit);
    send_byte(8'h5C, echo, ack_bit);
    bit_cycle(1'b1, seen); bit_cycle(1'b0, seen);
    bit_cycle(1'b1, seen); bit_cycle(1'b1, seen);
    m_low = 1'b0; wait_clk(Q);
    sioc  = 1'b1; wait_clk(2);
    rst   = 1'b1;
    wait_clk(1);
    check("wdata reset siod", siod, 1'b1);
    check("wdata reset wr_en", wr_en, 1'b0);
    wait_clk(3);
    rst = 1'b0;
    wait_clk(Q);
    check("wdata reset no write", wr_log.size(), 0);
    check("wdata reset rd_addr", rd_addr, 8'h00);
    wr_log.delete();
    write3(WR_ID, 8'h3A, 8'h04, acks);
    check("post-reset acks", acks, 3'b111);
    check("post-reset write count", wr_log.size(), 1);
    if (wr_log.size() > 0) check("post-reset write", wr_log[0], 16'h3A04);
    mem[8'h3A] = 8'h04;

    // Repeated START inside WDATA abandons the partial byte; the restarted write lands once.
    wr_log.delete();
    bus_start();
    send_byte(WR_ID, echo, ack_bit);
    send_byte(8'h55, echo, ack_bit);
    bit_cycle(1'b0, seen); bit_cycle(1'b1, seen); bit_cycle(1'b1, seen);
    write3(WR_ID, 8'h11, 8'h01, acks);
    check("restart acks", acks, 3'b111);
    check("restart write count", wr_log.size(), 1);
    if (wr_log.size() > 0) check("restart write", wr_log[0], 16'h1101);
    check("restart rd_addr", rd_addr, 8'h11);
    mem[8'h11] = 8'h01;
    m_addr     = 8'h11;

    run_random(30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sccb_responder.md
SCCB_RESPONDER -- requirements
Module: sccb_responder

Interface
REQ-001 SHALL have parameter DEVICE_ID, default 8'h42, meaning the 8-bit write ID; read ID is DEVICE_ID|1.
REQ-002 SHALL have parameter REG_AW, default 8, meaning the sub-address width; must be 8.
REQ-003 SHALL have port clk  input  1  system clock, single clock domain; reset is synchronous and active-high.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port sioc  input  1  SCCB clock from the master; asynchronous to clk.
REQ-006 SHALL have port siod  inout  1  SCCB data, open-drain: the block drives only 0 or high-Z.
REQ-007 SHALL have port wr_en  output  1  one-cycle register write strobe.
REQ-008 SHALL have port wr_addr  output  8  register sub-address for the write.
REQ-009 SHALL have port wr_data  output  8  register value for the write.
REQ-010 SHALL have port rd_addr  output  8  last received sub-address, held until overwritten.
REQ-011 SHALL have port rd_data  input  8  register value for rd_addr, supplied combinationally or registered.
REQ-012 SHALL have port busy  output  1  high from a START to the matching STOP when the transaction is addressed to this device.

Function
REQ-013 SHALL pass sioc and siod through 2-FF synchronizers, then detect edges on the synchronized values; clk SHALL be at least 16x the sioc frequency.
REQ-014 SHALL detect START as a synchronized siod fall while sioc is high, and STOP as a siod rise while sioc is high.
REQ-015 SHALL sample data bits on the sioc rising edge, MSB first, and change driven siod only on the sioc falling edge.
REQ-016 SHALL implement states IDLE, ID, ID_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RD_NACK, IGNORE.
REQ-017 SHALL move to ID with the bit counter cleared on a START from any state, including a repeated START.
REQ-018 SHALL move to IDLE with siod released on a STOP from any state.
REQ-019 SHALL, after 8 ID bits:
 - ID == DEVICE_ID: go to ID_ACK.
 - ID == DEVICE_ID|1: go to ID_ACK, then RDATA.
 - any other ID: go to IGNORE.
REQ-020 SHALL, in IGNORE, never drive siod and never assert wr_en until the next START or STOP.
REQ-021 SHALL drive siod low for the full 9th bit of ID_ACK, SUB_ACK and WDATA_ACK, and release it on the following sioc fall.
REQ-022 SHALL load the 8 sub-address bits received in SUB into rd_addr at the end of SUB.
REQ-023 SHALL pulse wr_en for exactly one clk, with wr_addr = rd_addr and wr_data = the received byte, within 2 clk of the 8th WDATA bit being sampled.
REQ-024 SHALL go to IGNORE after WDATA_ACK, so extra data bytes cause no write and no auto-increment.
REQ-025 SHALL latch rd_data on entry to RDATA and shift it out MSB first: drive 0 for a 0 bit, high-Z for a 1 bit.
REQ-026 SHALL release siod during RD_NACK and then go to IGNORE, whatever the master's ack value.
REQ-027 SHALL perform no write and leave rd_addr unchanged if a STOP or START arrives before the sub-address phase completes.
REQ-028 SHALL hold rd_addr after a STOP that follows a completed sub-address phase (2-phase write), for use by a later read.

Reset
REQ-029 SHALL, while rst is high, force: state IDLE, siod high-Z, wr_en 0, wr_addr 0, wr_data 0, rd_addr 0, busy 0, synchronizers to 1.
REQ-030 SHALL release siod within 1 clk of rst asserting mid-transaction and SHALL NOT emit wr_en.

Structure
REQ-031 SHALL place the state enum and the default SCCB_WRITE_ID (8'h42) in shared package sccb_pkg.
REQ-032 SHALL use one sub-module, sccb_line_sync, for the synchronizer plus rise/fall edge detect, instantiated once per line.

Verification
REQ-033 SHALL cover: 3-phase write 0x42, 0x12, 0x80 -> one wr_en pulse, wr_addr=0x12, wr_data=0x80, siod low in all three ack bits.
REQ-034 SHALL cover: write ID 0x40 -> siod never driven, wr_en never asserted, busy stays 0.
REQ-035 SHALL cover: 0x42, 0x0A, STOP, then START, 0x43 with rd_data=0x76 -> siod pattern 0,1,1,1,0,1,1,0 (1 = high-Z); rd_addr=0x0A; no wr_en.
REQ-036 SHALL cover: STOP after the 4th sub-address bit -> no wr_en, rd_addr unchanged, state IDLE.
REQ-037 SHALL cover: rst asserted at the 5th WDATA bit -> siod high-Z next clk, no wr_en; a following full write 0x42, 0x3A, 0x04 is accepted normally.
REQ-038 SHALL cover: repeated START during WDATA followed by 0x42, 0x11, 0x01 -> exactly one wr_en, with wr_addr=0x11 and wr_data=0x01.
